// File: rtl/monster_path_finder.sv
// BFS shortest-path engine: floods the map from the player cell, then reports the monster's
// distance to the player and the first step direction along a shortest path.
module monster_path_finder #(
   parameter int unsigned MAP_ROWS = 15,
   parameter int unsigned MAP_COLS = 20,
   parameter int unsigned DIST_W   = 10,
   parameter int unsigned IDX_W    = 9
) (
   input  logic              clk_13,
   input  logic              rst_n,
   input  logic              start,
   input  logic [9:0]        player_r,
   input  logic [9:0]        player_c,
   input  logic [9:0]        monster_r,
   input  logic [9:0]        monster_c,
   output logic [9:0]        map_rd_r,
   output logic [9:0]        map_rd_c,
   input  logic [2:0]        map_tile,
   output logic              busy,
   output logic              done,
   output logic [DIST_W-1:0] dist_to_player,
   output logic [2:0]        dir_to_player
);

   localparam int unsigned N     = MAP_ROWS * MAP_COLS;
   localparam int unsigned POS_W = 10;
   localparam int unsigned ROW_W = $clog2(MAP_ROWS);
   localparam int unsigned COL_W = $clog2(MAP_COLS);
   localparam int unsigned RC_W  = ROW_W + COL_W;

   localparam logic [DIST_W-1:0] INF       = {DIST_W{1'b1}};
   localparam logic [2:0]        TILE_WALL = 3'b010;
   localparam logic [2:0]        DIR_STOP  = 3'd0;
   localparam logic [2:0]        DIR_DOWN  = 3'd1;
   localparam logic [2:0]        DIR_UP    = 3'd2;
   localparam logic [2:0]        DIR_LEFT  = 3'd3;
   localparam logic [2:0]        DIR_RIGHT = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SEED, S_POP, S_NB_ADDR, S_NB_EVAL, S_RESOLVE, S_RESULT
   } state_t;

   typedef struct packed {
      logic             ok;
      logic [ROW_W-1:0] r;
      logic [COL_W-1:0] c;
   } nb_t;

   function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
      return IDX_W'(32'(r) * MAP_COLS + 32'(c));
   endfunction

   // Neighbour k of (r,c) in search order UP, DOWN, LEFT, RIGHT; ok=0 when off-grid.
   function automatic nb_t neighbour(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c,
                                     input logic [1:0] k);
      nb_t n;
      n.ok = 1'b0;
      n.r  = r;
      n.c  = c;
      case (k)
         2'd0:    begin n.ok = (r != '0);                n.r = r - ROW_W'(1); end
         2'd1:    begin n.ok = (32'(r) + 1 < MAP_ROWS);  n.r = r + ROW_W'(1); end
         2'd2:    begin n.ok = (c != '0);                n.c = c - COL_W'(1); end
         default: begin n.ok = (32'(c) + 1 < MAP_COLS);  n.c = c + COL_W'(1); end
      endcase
      return n;
   endfunction

   function automatic logic [2:0] dir_of(input logic [1:0] k);
      case (k)
         2'd0:    return DIR_UP;
         2'd1:    return DIR_DOWN;
         2'd2:    return DIR_LEFT;
         default: return DIR_RIGHT;
      endcase
   endfunction

   state_t            state;
   logic [ROW_W-1:0]  pl_r, mo_r, u_r;
   logic [COL_W-1:0]  pl_c, mo_c, u_c;
   logic [IDX_W-1:0]  clr_idx, q_head, q_tail;
   logic [DIST_W-1:0] u_dist, res_dist;
   logic [2:0]        res_dir;
   logic [1:0]        k;

   logic [DIST_W-1:0] dist_mem [N];
   logic [RC_W-1:0]   q_mem    [N];

   logic              dist_we, q_we;
   logic [IDX_W-1:0]  dist_waddr, v_idx;
   logic [DIST_W-1:0] dist_wdata, v_dist, mo_dist_c;
   logic [RC_W-1:0]   q_wdata, q_out;
   logic [ROW_W-1:0]  pop_r;
   logic [COL_W-1:0]  pop_c;
   nb_t               nb_cur, nb_nxt, nb_pop, res_nb;
   logic [2:0]        res_dir_c;

   always_comb begin
      q_out  = q_mem[q_head];
      pop_r  = q_out[RC_W-1:COL_W];
      pop_c  = q_out[COL_W-1:0];
      nb_cur = neighbour(u_r, u_c, k);
      nb_nxt = neighbour(u_r, u_c, k + 2'd1);
      nb_pop = neighbour(pop_r, pop_c, 2'd0);
      v_idx  = cell_idx(nb_cur.r, nb_cur.c);
      v_dist = dist_mem[v_idx];
   end

   // First-step resolve: scan in reverse so the earliest direction in search order wins ties.
   always_comb begin
      res_dir_c = DIR_STOP;
      res_nb    = '0;
      mo_dist_c = dist_mem[cell_idx(mo_r, mo_c)];
      if (mo_dist_c != '0 && mo_dist_c != INF) begin
         for (int i = 3; i >= 0; i--) begin
            res_nb = neighbour(mo_r, mo_c, 2'(i));
            if (res_nb.ok && dist_mem[cell_idx(res_nb.r, res_nb.c)] == mo_dist_c - DIST_W'(1))
               res_dir_c = dir_of(2'(i));
         end
      end
   end

   always_comb begin
      dist_we    = 1'b0;
      dist_waddr = clr_idx;
      dist_wdata = INF;
      q_we       = 1'b0;
      q_wdata    = {nb_cur.r, nb_cur.c};
      case (state)
         S_CLEAR: dist_we = 1'b1;
         S_SEED: begin
            dist_we    = 1'b1;
            dist_waddr = cell_idx(pl_r, pl_c);
            dist_wdata = '0;
            q_we       = 1'b1;
            q_wdata    = {pl_r, pl_c};
         end
         S_NB_EVAL: begin
            if (map_tile != TILE_WALL && v_dist == INF) begin
               dist_we    = 1'b1;
               dist_waddr = v_idx;
               dist_wdata = u_dist + DIST_W'(1);
               q_we       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Storage arrays carry no reset; CLEAR initialises every entry before use.
   always_ff @(posedge clk_13) begin
      if (dist_we) dist_mem[dist_waddr] <= dist_wdata;
      if (q_we)    q_mem[q_tail]        <= q_wdata;
   end

   always_ff @(posedge clk_13 or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         dist_to_player <= INF;
         dir_to_player  <= DIR_STOP;
         map_rd_r       <= '0;
         map_rd_c       <= '0;
         pl_r           <= '0;
         pl_c           <= '0;
         mo_r           <= '0;
         mo_c           <= '0;
         u_r            <= '0;
         u_c            <= '0;
         u_dist         <= '0;
         clr_idx        <= '0;
         q_head         <= '0;
         q_tail         <= '0;
         k              <= '0;
         res_dist       <= INF;
         res_dir        <= DIR_STOP;
      end else begin
         done <= 1'b0;
         if (q_we) q_tail <= q_tail + IDX_W'(1);
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (player_r >= POS_W'(MAP_ROWS) || player_c >= POS_W'(MAP_COLS) ||
                      monster_r >= POS_W'(MAP_ROWS) || monster_c >= POS_W'(MAP_COLS)) begin
                     res_dist <= INF;
                     res_dir  <= DIR_STOP;
                     state    <= S_RESULT;
                  end else begin
                     pl_r    <= ROW_W'(player_r);
                     pl_c    <= COL_W'(player_c);
                     mo_r    <= ROW_W'(monster_r);
                     mo_c    <= COL_W'(monster_c);
                     clr_idx <= '0;
                     q_head  <= '0;
                     q_tail  <= '0;
                     busy    <= 1'b1;
                     state   <= S_CLEAR;
                  end
               end
            end
            S_CLEAR: begin
               if (clr_idx == IDX_W'(N - 1)) state <= S_SEED;
               else clr_idx <= clr_idx + IDX_W'(1);
            end
            S_SEED: state <= S_POP;
            // Pop also preloads the first neighbour address so the tile lands in NB_EVAL.
            S_POP: begin
               if (q_head == q_tail) begin
                  state <= S_RESOLVE;
               end else begin
                  u_r    <= pop_r;
                  u_c    <= pop_c;
                  u_dist <= dist_mem[cell_idx(pop_r, pop_c)];
                  q_head <= q_head + IDX_W'(1);
                  k      <= '0;
                  if (nb_pop.ok) begin
                     map_rd_r <= POS_W'(nb_pop.r);
                     map_rd_c <= POS_W'(nb_pop.c);
                  end
                  state <= S_NB_ADDR;
               end
            end
            S_NB_ADDR: begin
               if (nb_cur.ok) begin
                  state <= S_NB_EVAL;
               end else if (k == 2'd3) begin
                  state <= S_POP;
               end else begin
                  k <= k + 2'd1;
                  if (nb_nxt.ok) begin
                     map_rd_r <= POS_W'(nb_nxt.r);
                     map_rd_c <= POS_W'(nb_nxt.c);
                  end
               end
            end
            S_NB_EVAL: begin
               if (k == 2'd3) begin
                  state <= S_POP;
               end else begin
                  k <= k + 2'd1;
                  if (nb_nxt.ok) begin
                     map_rd_r <= POS_W'(nb_nxt.r);
                     map_rd_c <= POS_W'(nb_nxt.c);
                  end
                  state <= S_NB_ADDR;
               end
            end
            S_RESOLVE: begin
               res_dist <= mo_dist_c;
               res_dir  <= res_dir_c;
               state    <= S_RESULT;
            end
            S_RESULT: begin
               dist_to_player <= res_dist;
               dir_to_player  <= res_dir;
               done           <= 1'b1;
               busy           <= 1'b0;
               state          <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
